// File: rtl/voice_mix_scheduler.sv
// voice_mix_scheduler: shares one synchronous sample-table read port among
// NUM_VOICES oscillator voices once per audio frame. Each enabled voice reads
// the table at the top bits of its phase accumulator. Its sample is scaled by
// volume/2^VOLUME_BITS, added into a wide accumulator, and the accumulator is
// saturated into a SAMPLE_BITS mix word for the I2S transmitter.
// Optional feature macro: VOICE_MIX_PHASE_RESET_EN. When it is defined, a
// disabled voice has its phase cleared to 0 in its slot.
module voice_mix_scheduler #(
    parameter int NUM_VOICES  = 4,
    parameter int SAMPLE_BITS = 16,
    parameter int ADDR_BITS   = 8,
    parameter int PHASE_BITS  = 16,
    parameter int VOLUME_BITS = 4
) (
    input  logic                                mclk,
    input  logic                                rst,
    input  logic                                frame_tick,
    input  logic [NUM_VOICES-1:0]               voice_en,
    input  logic [NUM_VOICES*PHASE_BITS-1:0]    voice_step,
    input  logic [NUM_VOICES*VOLUME_BITS-1:0]   voice_volume,
    output logic                                tbl_rd,
    output logic [ADDR_BITS-1:0]                tbl_addr,
    input  logic signed [SAMPLE_BITS-1:0]       tbl_data,
    output logic signed [SAMPLE_BITS-1:0]       mix_out,
    output logic                                mix_valid,
    output logic                                busy,
    output logic                                overrun
);

    localparam int ACC_BITS  = SAMPLE_BITS + $clog2(NUM_VOICES) + 1;
    localparam int PROD_BITS = SAMPLE_BITS + VOLUME_BITS + 1;
    localparam int VIDX_BITS = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [VIDX_BITS-1:0] LAST_IDX = VIDX_BITS'(NUM_VOICES - 1);
    localparam logic signed [ACC_BITS-1:0] SAT_MAX =
        {{(ACC_BITS-SAMPLE_BITS+1){1'b0}}, {(SAMPLE_BITS-1){1'b1}}};
    localparam logic signed [ACC_BITS-1:0] SAT_MIN =
        {{(ACC_BITS-SAMPLE_BITS+1){1'b1}}, {(SAMPLE_BITS-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ISSUE, ACCUM, DONE} state_t;

    state_t                        state;
    logic [VIDX_BITS-1:0]          idx;
    logic signed [ACC_BITS-1:0]    acc;
    logic [PHASE_BITS-1:0]         phase     [NUM_VOICES];

    logic [NUM_VOICES-1:0]         en_snap;
    logic [PHASE_BITS-1:0]         step_snap [NUM_VOICES];
    logic [VOLUME_BITS-1:0]        vol_snap  [NUM_VOICES];

    logic signed [PROD_BITS-1:0]   prod;
    logic signed [ACC_BITS-1:0]    contrib;
    logic signed [ACC_BITS-1:0]    acc_sum;
    logic signed [SAMPLE_BITS-1:0] mix_sat;
    logic [VIDX_BITS-1:0]          next_idx;
    logic [ADDR_BITS-1:0]          first_addr;
    logic [ADDR_BITS-1:0]          next_addr;

    // Capture the voice settings at frame start so later input changes are ignored.
    // NOTE: snapshot registers have no reset; they are always written before they are read.
    always_ff @(posedge mclk) begin
        if (state == IDLE && frame_tick) begin
            en_snap <= voice_en;
            for (int v = 0; v < NUM_VOICES; v++) begin
                step_snap[v] <= voice_step[v*PHASE_BITS +: PHASE_BITS];
                vol_snap[v]  <= voice_volume[v*VOLUME_BITS +: VOLUME_BITS];
            end
        end
    end

    // Scale the current voice's sample, and form the next read address and the saturated mix.
    // NOTE: every always_comb output is given a value on every path, so no latch is inferred.
    always_comb begin
        prod       = PROD_BITS'($signed(tbl_data)) *
                     PROD_BITS'($signed({1'b0, vol_snap[idx]}));
        contrib    = ACC_BITS'(prod >>> VOLUME_BITS);
        acc_sum    = acc + contrib;
        next_idx   = idx + VIDX_BITS'(1);
        first_addr = phase[0][PHASE_BITS-1 -: ADDR_BITS];
        next_addr  = phase[next_idx][PHASE_BITS-1 -: ADDR_BITS];
        if (acc > SAT_MAX) begin
            mix_sat = SAMPLE_BITS'(SAT_MAX);
        end else if (acc < SAT_MIN) begin
            mix_sat = SAMPLE_BITS'(SAT_MIN);
        end else begin
            mix_sat = SAMPLE_BITS'(acc);
        end
    end

    // Frame sequencer: issue a read and accumulate it for each voice, then publish the mix.
    // NOTE: all state in this block uses non-blocking assignments, so every register sees values from before the edge.
    always_ff @(posedge mclk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            tbl_rd    <= 1'b0;
            tbl_addr  <= '0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            // NOTE: phases are architectural state, so the whole array is cleared by reset.
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase[v] <= '0;
            end
        end else begin
            mix_valid <= 1'b0;
            if (frame_tick && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (frame_tick) begin
                        acc    <= '0;
                        idx    <= '0;
                        busy   <= 1'b1;
                        tbl_rd <= voice_en[0];
                        if (voice_en[0]) begin
                            tbl_addr <= first_addr;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    tbl_rd <= 1'b0;
                    state  <= ACCUM;
                end
                ACCUM: begin
                    if (en_snap[idx]) begin
                        acc        <= acc_sum;
                        phase[idx] <= phase[idx] + step_snap[idx];
                    end
`ifdef VOICE_MIX_PHASE_RESET_EN
                    else begin
                        phase[idx] <= '0;
                    end
`endif
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        idx    <= next_idx;
                        tbl_rd <= en_snap[next_idx];
                        if (en_snap[next_idx]) begin
                            tbl_addr <= next_addr;
                        end
                        state <= ISSUE;
                    end
                end
                DONE: begin
                    mix_out   <= mix_sat;
                    mix_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
